// File: rtl/ilv_pkg.sv
// Shared types and PB-size decoding for the turbo interleaver address sequencer.
package ilv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2,
        ST_READ  = 2'd3
    } ilv_state_e;

    localparam int unsigned PB16_LEN  = 64;
    localparam int unsigned PB136_LEN = 544;
    localparam int unsigned PB520_LEN = 2080;

    localparam logic [11:0] PB16_OFF  = 12'h000;
    localparam logic [11:0] PB136_OFF = 12'h040;
    localparam logic [11:0] PB520_OFF = 12'h260;

    typedef struct packed {
        logic        valid;
        logic [11:0] offset;
    } pb_dec_t;

    function automatic pb_dec_t pb_decode(input logic [31:0] len);
        pb_dec_t d;
        d.valid  = 1'b1;
        d.offset = 12'h000;
        case (len)
            PB16_LEN:  d.offset = PB16_OFF;
            PB136_LEN: d.offset = PB136_OFF;
            PB520_LEN: d.offset = PB520_OFF;
            default:   d.valid  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ilv_addr_seq_if.sv
// Control and RAM-address bundle between the PB controller and the interleaver sequencer.
interface ilv_addr_seq_if #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 12
);
    // din_vld/rd_rdy qualify a transfer in the cycle they are sampled high; the
    // matching wr_en/rd_en and address appear registered on the following cycle.
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              din_vld;
    logic              rd_rdy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] pb_offset;
    logic              bank;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, len, abort, din_vld, rd_rdy,
        input  wr_en, wr_addr, rd_en, rd_addr, pb_offset, bank, busy, done, err
    );

    modport slave (
        input  start, len, abort, din_vld, rd_rdy,
        output wr_en, wr_addr, rd_en, rd_addr, pb_offset, bank, busy, done, err
    );
endinterface

// File: rtl/ilv_cnt.sv
// Sample counter shared by the write and read sweeps; tc_o flags the last sample of the PB.
module ilv_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);
endmodule

// File: rtl/ilv_addr_seq.sv
// Per-PB write-then-read address sequencer for the interleaver RAM with ping-pong banks.
module ilv_addr_seq
    import ilv_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 12,
    parameter int RD_GAP = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    ilv_addr_seq_if.slave        bus,
    output ilv_state_e           dbg_state_o
);
    localparam logic [3:0] GAP_LAST = 4'((RD_GAP > 0) ? RD_GAP - 1 : 0);

    ilv_state_e        state_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] off_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [3:0]        gap_q;
    logic              bank_q, wr_en_q, rd_en_q, busy_q, done_q, err_q;

    logic [ADDR_W-1:0] cnt, last;
    logic              tc, start_ok, wr_acc, rd_acc, aborting, cnt_clr, cnt_en;
    pb_dec_t           dec;

    assign dec  = pb_decode(32'(bus.len));
    assign last = ADDR_W'(len_q - LEN_W'(1));

    always_comb begin
        aborting = (state_q != ST_IDLE) && bus.abort;
        start_ok = (state_q == ST_IDLE) && bus.start && dec.valid;
        wr_acc   = (state_q == ST_WRITE) && bus.din_vld && !bus.abort;
        rd_acc   = (state_q == ST_READ) && bus.rd_rdy && !bus.abort;
        cnt_en   = wr_acc || rd_acc;
        // Clearing on the terminal sample hands a zeroed counter to the next phase.
        cnt_clr  = start_ok || aborting || (cnt_en && tc);
    end

    ilv_cnt #(.W(ADDR_W)) u_cnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .last_i (last),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            off_q     <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            gap_q     <= '0;
            bank_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (aborting) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            if (dec.valid) begin
                                len_q   <= bus.len;
                                off_q   <= ADDR_W'(dec.offset);
                                state_q <= ST_WRITE;
                                busy_q  <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (bus.din_vld) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= off_q + cnt;
                            if (tc) begin
                                state_q <= (RD_GAP == 0) ? ST_READ : ST_GAP;
                                gap_q   <= '0;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_q == GAP_LAST) begin
                            state_q <= ST_READ;
                        end else begin
                            gap_q <= gap_q + 4'd1;
                        end
                    end
                    ST_READ: begin
                        if (bus.rd_rdy) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= off_q + cnt;
                            if (tc) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                bank_q  <= ~bank_q;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.pb_offset = off_q;
    assign bus.bank      = bank_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_ilv_addr_seq.sv
// Directed bench for ilv_addr_seq: PB16/PB136/PB520 sweeps, length error, abort, back-to-back, reset.
module tb_ilv_addr_seq;
    import ilv_pkg::*;

    logic       clk;
    logic       n_rst;
    ilv_state_e dbg_state;
    int         n_chk;
    int         n_fail;

    ilv_addr_seq_if #(.ADDR_W(12), .LEN_W(12)) bus ();

    ilv_addr_seq #(.ADDR_W(12), .LEN_W(12), .RD_GAP(1)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
        chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
        chk({tag, "_pb_offset"}, 32'(bus.pb_offset), 0);
        chk({tag, "_bank"}, 32'(bus.bank), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
        chk({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    task automatic do_start(input int len, input int exp_off, input int exp_bank);
        bus.start = 1'b1;
        bus.len   = 12'(len);
        tick();
        bus.start = 1'b0;
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_offset", 32'(bus.pb_offset), 32'(exp_off));
        chk("start_bank", 32'(bus.bank), 32'(exp_bank));
        chk("start_err", 32'(bus.err), 0);
        chk("start_wr_en", 32'(bus.wr_en), 0);
    endtask

    task automatic write_phase(input int n, input int off, input bit toggle);
        int  c;
        bit  d;
        c = 0;
        d = 1'b1;
        while (c < n) begin
            bus.din_vld = d;
            tick();
            if (d) begin
                chk("wr_en", 32'(bus.wr_en), 1);
                chk("wr_addr", 32'(bus.wr_addr), 32'(off + c));
                c++;
            end else begin
                chk("wr_idle", 32'(bus.wr_en), 0);
            end
            if (toggle) d = !d;
        end
        bus.din_vld = 1'b0;
    endtask

    task automatic read_phase(input int n, input int off, input int stall_at,
                              input int stall_len, input int exp_bank);
        int c;
        int s;
        bit r;
        c = 0;
        s = 0;
        bus.rd_rdy = 1'b0;
        tick();
        chk("gap_rd_en", 32'(bus.rd_en), 0);
        chk("gap_wr_en", 32'(bus.wr_en), 0);
        chk("gap_busy", 32'(bus.busy), 1);
        while (c < n) begin
            r = !(c == stall_at && s < stall_len);
            if (!r) s++;
            bus.rd_rdy = r;
            tick();
            if (r) begin
                chk("rd_en", 32'(bus.rd_en), 1);
                chk("rd_addr", 32'(bus.rd_addr), 32'(off + c));
                if (c == n - 1) begin
                    chk("done_pulse", 32'(bus.done), 1);
                    chk("done_busy", 32'(bus.busy), 0);
                    chk("done_bank", 32'(bus.bank), 32'(exp_bank));
                    chk("done_state", 32'(dbg_state), 0);
                end else begin
                    chk("early_done", 32'(bus.done), 0);
                end
                c++;
            end else begin
                chk("stall_rd_en", 32'(bus.rd_en), 0);
                chk("stall_rd_addr", 32'(bus.rd_addr), 32'(off + c - 1));
            end
        end
        bus.rd_rdy = 1'b0;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        n_rst       = 1'b0;
        bus.start   = 1'b0;
        bus.len     = '0;
        bus.abort   = 1'b0;
        bus.din_vld = 1'b0;
        bus.rd_rdy  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        n_rst = 1'b1;
        tick();

        // PB16, din_vld held high including the start cycle
        bus.din_vld = 1'b1;
        do_start(64, 12'h000, 0);
        write_phase(64, 12'h000, 1'b0);
        read_phase(64, 12'h000, -1, 0, 1);
        tick();
        chk("pb16_after_done", 32'(bus.done), 0);
        chk("pb16_after_rd_en", 32'(bus.rd_en), 0);

        // PB136, din_vld toggling, 10-cycle rd_rdy stall mid-read
        do_start(544, 12'h040, 1);
        write_phase(544, 12'h040, 1'b1);
        read_phase(544, 12'h040, 100, 10, 0);
        tick();

        // PB520 reaches the top address 0xA7F
        do_start(2080, 12'h260, 0);
        write_phase(2080, 12'h260, 1'b0);
        chk("pb520_last_wr", 32'(bus.wr_addr), 32'h0000_0A7F);
        read_phase(2080, 12'h260, -1, 0, 1);
        chk("pb520_last_rd", 32'(bus.rd_addr), 32'h0000_0A7F);
        tick();
        chk("pb520_busy_after", 32'(bus.busy), 0);
        chk("pb520_done_after", 32'(bus.done), 0);

        // Unsupported length
        bus.start = 1'b1;
        bus.len   = 12'd100;
        tick();
        bus.start = 1'b0;
        chk("err_pulse", 32'(bus.err), 1);
        chk("err_busy", 32'(bus.busy), 0);
        chk("err_offset", 32'(bus.pb_offset), 32'h260);
        tick();
        chk("err_clear", 32'(bus.err), 0);
        chk("err_idle", 32'(bus.busy), 0);
        do_start(64, 12'h000, 1);
        write_phase(64, 12'h000, 1'b0);
        read_phase(64, 12'h000, -1, 0, 0);
        tick();

        // Abort after 30 writes, with a stray start during WRITE
        do_start(64, 12'h000, 0);
        write_phase(30, 12'h000, 1'b0);
        bus.start = 1'b1;
        bus.len   = 12'd544;
        tick();
        bus.start = 1'b0;
        chk("busy_start_err", 32'(bus.err), 0);
        chk("busy_start_busy", 32'(bus.busy), 1);
        chk("busy_start_offset", 32'(bus.pb_offset), 0);
        bus.abort   = 1'b1;
        bus.din_vld = 1'b1;
        tick();
        bus.abort   = 1'b0;
        bus.din_vld = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_wr_en", 32'(bus.wr_en), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_bank", 32'(bus.bank), 0);
        chk("abort_state", 32'(dbg_state), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", 32'(bus.done), 0);
            chk("abort_idle", 32'(bus.busy), 0);
        end

        // Back-to-back PB16 with start in the done cycle, then reset mid-READ
        do_start(64, 12'h000, 0);
        write_phase(64, 12'h000, 1'b0);
        read_phase(64, 12'h000, -1, 0, 1);
        do_start(64, 12'h000, 1);
        write_phase(64, 12'h000, 1'b0);
        bus.rd_rdy = 1'b0;
        tick();
        bus.rd_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("b2b_rd_addr", 32'(bus.rd_addr), 32'(i));
            chk("b2b_bank", 32'(bus.bank), 1);
        end
        n_rst = 1'b0;
        #2;
        chk_all_zero("async_rst");
        bus.rd_rdy = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_state", 32'(dbg_state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
